esc_quad_drv: RTL

//  Consumer end of the flght_cntrl motor-speed interface: takes the four 11-bit motor speeds
//  (frnt/bck/lft/rght) plus an update strobe and drives four ESC servo-style PWM outputs.

---
 rtl/esc_quad_drv.sv | 111 +++++++++++
 1 files changed

// File: rtl/esc_quad_drv.sv
// Four-channel ESC servo PWM driver with frame-synchronous double-buffered speeds
// and a watchdog that drops every motor to minimum pulse when updates stop.
module esc_quad_drv #(
   parameter int PERIOD_BITS = 18,
   parameter int MIN_CLKS    = 50000,
   parameter int SCALE       = 25,
   parameter int WD_PERIODS  = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        upd_vld,
   input  logic [10:0] frnt_spd,
   input  logic [10:0] bck_spd,
   input  logic [10:0] lft_spd,
   input  logic [10:0] rght_spd,
   output logic        pwm_frnt,
   output logic        pwm_bck,
   output logic        pwm_lft,
   output logic        pwm_rght,
   output logic        frm_strt,
   output logic        armed,
   output logic        stale
);

   if (MIN_CLKS + 2047 * SCALE >= 2 ** PERIOD_BITS) begin : g_bad_width
      $error("esc_quad_drv: maximum pulse does not fit in one frame");
   end
   if (WD_PERIODS < 1 || WD_PERIODS > 255) begin : g_bad_wd
      $error("esc_quad_drv: WD_PERIODS must be 1..255");
   end

   typedef enum logic [1:0] {DISARM, RUN, FAILSAFE} state_t;

   localparam logic [PERIOD_BITS-1:0] MIN_W   = PERIOD_BITS'(MIN_CLKS);
   localparam logic [PERIOD_BITS-1:0] SCALE_W = PERIOD_BITS'(SCALE);
   localparam logic [7:0]             WD_MAX  = 8'(WD_PERIODS);
   localparam logic [7:0]             WD_LAST = 8'(WD_PERIODS - 1);

   state_t                       state, state_nxt;
   logic [PERIOD_BITS-1:0]       prd_cnt;
   logic [7:0]                   wd_cnt;
   logic [3:0][10:0]             shd;        // 0 frnt, 1 bck, 2 lft, 3 rght
   logic [3:0][PERIOD_BITS-1:0]  act_w;
   logic [3:0][PERIOD_BITS-1:0]  act_w_nxt;
   logic [3:0]                   pwm_q;
   logic                         load;
   logic                         use_spd;

   assign load = &prd_cnt;

   always_comb begin
      state_nxt = state;
      case (state)
         DISARM:   if (upd_vld) state_nxt = RUN;
         RUN:      if (load && !upd_vld && (wd_cnt == WD_LAST)) state_nxt = FAILSAFE;
         FAILSAFE: if (upd_vld) state_nxt = RUN;
         default:  state_nxt = DISARM;
      endcase
   end

   // A timeout on the load edge already forces minimum widths for the coming frame.
   assign use_spd = (state == RUN) && (state_nxt == RUN);

   always_comb begin
      act_w_nxt = '0;
      for (int i = 0; i < 4; i++) begin
         act_w_nxt[i] = use_spd ? (MIN_W + PERIOD_BITS'(shd[i]) * SCALE_W) : MIN_W;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= DISARM;
         prd_cnt  <= '0;
         wd_cnt   <= '0;
         shd      <= '0;
         act_w    <= {4{MIN_W}};
         pwm_q    <= '0;
         frm_strt <= 1'b0;
         armed    <= 1'b0;
         stale    <= 1'b0;
      end else begin
         state    <= state_nxt;
         prd_cnt  <= prd_cnt + 1'b1;
         frm_strt <= (prd_cnt == '0);
         armed    <= (state == RUN);
         stale    <= (state == FAILSAFE);
         for (int i = 0; i < 4; i++) begin
            pwm_q[i] <= (prd_cnt < act_w[i]);
         end
         if (upd_vld) begin
            shd <= {rght_spd, lft_spd, bck_spd, frnt_spd};
         end
         // Active widths read the shadow value from before any same-edge update.
         if (load) begin
            act_w <= act_w_nxt;
         end
         if (upd_vld) begin
            wd_cnt <= '0;
         end else if (load && (wd_cnt != WD_MAX)) begin
            wd_cnt <= wd_cnt + 8'd1;
         end
      end
   end

   assign pwm_frnt = pwm_q[0];
   assign pwm_bck  = pwm_q[1];
   assign pwm_lft  = pwm_q[2];
   assign pwm_rght = pwm_q[3];

endmodule
